// File: rtl/cpu_pkg.sv
// Shared definitions for the trainer-board CPU front end: FSM encoding,
// instruction field positions and opcodes.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_FIRE    = 3'd2,
    ST_HELD    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam int CNT_W = 20;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int DST_MSB = 3;
  localparam int DST_LSB = 2;
  localparam int SRC_MSB = 1;
  localparam int SRC_LSB = 0;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser of configurable width with asynchronous active-low clear.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dip_instr_latch.sv
// Synchronises the DIP bank and activate button, debounces the button and hands one
// instruction per press to the CPU over valid/ready. Debounce built only with DIP_DEBOUNCE_EN.
module dip_instr_latch
  import cpu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] trainer_dip,
  input  logic       activate_button,
  input  logic       instr_ready,
  output logic [7:0] instr,
  output logic       instr_valid,
  output logic       overrun,
  output logic [7:0] instr_count,
  output logic       busy
);

  logic       btn_s;
  logic [7:0] dip_s;

  sync2 #(.WIDTH(1)) u_btn_sync (.clk(clk), .rst_n(rst_n), .d(activate_button), .q(btn_s));
  sync2 #(.WIDTH(8)) u_dip_sync (.clk(clk), .rst_n(rst_n), .d(trainer_dip),     .q(dip_s));

  state_t     state_q, state_d;
  logic [7:0] instr_q, instr_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic [7:0] count_q, count_d;
  logic       xfer;

  assign xfer = valid_q & instr_ready;

`ifdef DIP_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment so an oversized limit can never wrap back to zero.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_debounce;
  assign unused_debounce = ^DEBOUNCE_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    count_d   = count_q;
`ifdef DIP_DEBOUNCE_EN
    cnt_d     = cnt_q;
`endif

    if (xfer) begin
      valid_d = 1'b0;
      count_d = count_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
`ifdef DIP_DEBOUNCE_EN
          state_d = ST_ARM;
          cnt_d   = CNT_W'(1);
`else
          state_d = ST_FIRE;
`endif
        end
      end
`ifdef DIP_DEBOUNCE_EN
      ST_ARM: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LIMIT) begin
          state_d = ST_FIRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
`endif
      ST_FIRE: begin
        // A transfer in this same cycle frees the slot, so the new word may replace it.
        if (!valid_q || instr_ready) begin
          instr_d = dip_s;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        state_d = ST_HELD;
      end
      ST_HELD: begin
        if (!btn_s) begin
`ifdef DIP_DEBOUNCE_EN
          state_d = ST_RELEASE;
          cnt_d   = CNT_W'(1);
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef DIP_DEBOUNCE_EN
      ST_RELEASE: begin
        if (btn_s) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LIMIT) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      instr_q   <= 8'h00;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign overrun     = overrun_q;
  assign instr_count = count_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dip_instr_latch.sv
// Directed bench for dip_instr_latch; latency expectations follow DIP_DEBOUNCE_EN.
module tb_dip_instr_latch;

  localparam int DB = 4;
`ifdef DIP_DEBOUNCE_EN
  localparam int LAT          = DB + 3;
  localparam int BOUNCE_FIRES = 0;
`else
  localparam int LAT          = 3;
  localparam int BOUNCE_FIRES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] trainer_dip = 8'h00;
  logic       activate_button = 1'b0;
  logic       instr_ready = 1'b0;
  logic [7:0] instr;
  logic       instr_valid;
  logic       overrun;
  logic [7:0] instr_count;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  dip_instr_latch #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .trainer_dip(trainer_dip),
    .activate_button(activate_button), .instr_ready(instr_ready),
    .instr(instr), .instr_valid(instr_valid), .overrun(overrun),
    .instr_count(instr_count), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    activate_button = 1'b0;
    instr_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    exp_count = 0;
  endtask

  task automatic press(input logic [7:0] d, input int hold);
    trainer_dip = d;
    repeat (4) tick();
    activate_button = 1'b1;
    repeat (hold) tick();
    activate_button = 1'b0;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (instr !== 8'h00) begin n_bad++; $display("FAIL reset_instr: got %h expected 00", instr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_cmp++; if (instr_count !== 8'h00) begin n_bad++; $display("FAIL reset_count: got %h expected 00", instr_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    $display("reset held: instr=%h valid=%b overrun=%b count=%h busy=%b", instr, instr_valid, overrun, instr_count, busy);
    rst_n = 1'b1;
    tick();
    trainer_dip = 8'h1E;
    activate_button = 1'b1;
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midpress_busy: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
    $display("async reset mid-press: busy=%b", busy);
    activate_button = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (LAT + 4) tick();
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL aborted_press_valid: got %b expected 0", instr_valid); end
    exp_count = 0;
  endtask

  task automatic test_clean_press();
    instr_ready = 1'b1;
    trainer_dip = 8'b0001_1110;
    repeat (4) tick();
    activate_button = 1'b1;
    repeat (LAT) tick();
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL early_valid: got %b expected 0", instr_valid); end
    tick();
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL press_valid: got %b expected 1", instr_valid); end
    n_cmp++; if (instr !== 8'h1E) begin n_bad++; $display("FAIL press_instr: got %h expected 1e", instr); end
    tick();
    exp_count = 1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL post_xfer_valid: got %b expected 0", instr_valid); end
    n_cmp++; if (instr_count !== 8'(exp_count)) begin n_bad++; $display("FAIL clean_count: got %0d expected %0d", instr_count, exp_count); end
    repeat (20 - LAT - 2) tick();
    activate_button = 1'b0;
    repeat (16) tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL release_busy: got %b expected 0", busy); end
    $display("clean press: instr=%h count=%0d", instr, instr_count);
  endtask

  task automatic test_bounce();
    instr_ready = 1'b1;
    trainer_dip = 8'h55;
    repeat (4) tick();
    activate_button = 1'b1; tick();
    activate_button = 1'b0; tick();
    activate_button = 1'b1; tick();
    activate_button = 1'b0;
    repeat (20) tick();
    exp_count += BOUNCE_FIRES;
    n_cmp++; if (instr_count !== 8'(exp_count)) begin n_bad++; $display("FAIL bounce_count: got %0d expected %0d", instr_count, exp_count); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL bounce_valid: got %b expected 0", instr_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bounce_busy: got %b expected 0", busy); end
    $display("bounce: count=%0d valid=%b", instr_count, instr_valid);
  endtask

  task automatic test_backpressure();
    do_reset();
    instr_ready = 1'b0;
    press(8'h1E, 20);
    n_cmp++; if (instr !== 8'h1E) begin n_bad++; $display("FAIL bp_first_instr: got %h expected 1e", instr); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL bp_first_overrun: got %b expected 0", overrun); end
    press(8'h29, 20);
    n_cmp++; if (instr !== 8'h1E) begin n_bad++; $display("FAIL bp_kept_instr: got %h expected 1e", instr); end
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b expected 1", instr_valid); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL bp_overrun: got %b expected 1", overrun); end
    n_cmp++; if (instr_count !== 8'h00) begin n_bad++; $display("FAIL bp_count_before: got %0d expected 0", instr_count); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick();
    n_cmp++; if (instr_count !== 8'h01) begin n_bad++; $display("FAIL bp_count_after: got %0d expected 1", instr_count); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL bp_valid_after: got %b expected 0", instr_valid); end
    $display("backpressure: instr=%h overrun=%b count=%0d", instr, overrun, instr_count);
  endtask

  task automatic test_simultaneous();
    do_reset();
    instr_ready = 1'b0;
    press(8'h1E, 20);
    trainer_dip = 8'h29;
    repeat (4) tick();
    activate_button = 1'b1;
    repeat (LAT) tick();
    n_cmp++; if (instr !== 8'h1E) begin n_bad++; $display("FAIL sim_pre_instr: got %h expected 1e", instr); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_cmp++; if (instr !== 8'h29) begin n_bad++; $display("FAIL sim_instr: got %h expected 29", instr); end
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL sim_valid: got %b expected 1", instr_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL sim_overrun: got %b expected 0", overrun); end
    n_cmp++; if (instr_count !== 8'h01) begin n_bad++; $display("FAIL sim_count: got %0d expected 1", instr_count); end
    tick();
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL sim_valid_hold: got %b expected 1", instr_valid); end
    repeat (20) tick();
    activate_button = 1'b0;
    repeat (16) tick();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_cmp++; if (instr_count !== 8'h02) begin n_bad++; $display("FAIL sim_count_final: got %0d expected 2", instr_count); end
    $display("simultaneous: instr=%h overrun=%b count=%0d", instr, overrun, instr_count);
  endtask

  task automatic test_held();
    do_reset();
    instr_ready = 1'b1;
    press(8'h31, 100);
    n_cmp++; if (instr_count !== 8'h01) begin n_bad++; $display("FAIL held_count: got %0d expected 1", instr_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL held_busy: got %b expected 0", busy); end
    $display("held 100 cycles: count=%0d", instr_count);
  endtask

  task automatic test_wrap();
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      press(8'(i), LAT + 2);
      if (i == 254) begin
        n_cmp++; if (instr_count !== 8'd255) begin n_bad++; $display("FAIL wrap_255: got %0d expected 255", instr_count); end
      end
    end
    n_cmp++; if (instr_count !== 8'd0) begin n_bad++; $display("FAIL wrap_count: got %0d expected 0", instr_count); end
    n_cmp++; if (instr !== 8'hFF) begin n_bad++; $display("FAIL wrap_last_instr: got %h expected ff", instr); end
    $display("wrap after 256 presses: count=%0d last instr=%h", instr_count, instr);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_backpressure();
    test_simultaneous();
    test_held();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dip_instr_latch.md
# dip_instr_latch

Front-end stage that feeds the basic CPU its instructions from the trainer board. It synchronises the 8-bit DIP switch bank and the activate pushbutton, debounces the button, and presents one captured instruction per press on a valid/ready handshake. The CPU core sits directly downstream and consumes `instr` when it asserts `instr_ready`.

## Interface
- `DEBOUNCE_CYCLES`, default 250000, number of consecutive stable clocks required for press and release; legal range 1..2^20-1. At 50 MHz the default is 5 ms. Benches override it to 4.
- `clk` in 1: system clock; all state in this block is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low. It clears all state immediately.
- `trainer_dip` in 8: raw DIP instruction word, asynchronous. Fields: [7:4] opcode, [3:2] dest, [1:0] src.
- `activate_button` in 1: raw pushbutton, active-high, asynchronous, bouncy.
- `instr_ready` in 1: CPU can accept an instruction this cycle.
- `instr` out 8: captured instruction word.
- `instr_valid` out 1: `instr` holds an unconsumed instruction.
- `overrun` out 1: sticky flag; a press was dropped because the previous instruction was still pending.
- `instr_count` out 8: number of instructions accepted by the CPU; wraps modulo 256.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Synchronisers:
  - `activate_button` passes through a 2-FF synchroniser to give `btn_s`.
  - `trainer_dip` passes through a 2-FF synchroniser on all 8 bits to give `dip_s`.
- FSM states: IDLE, ARM, FIRE, HELD, RELEASE. The debounce counter is 20 bits and saturates.
  - **IDLE:** if `btn_s`=1, go to ARM with cnt=1.
  - **ARM:**
    - If `btn_s`=0, set cnt=0 and go to IDLE (bounce rejected).
    - Otherwise, if cnt==DEBOUNCE_CYCLES, go to FIRE.
    - Otherwise, cnt++.
  - **FIRE (one cycle):**
    - If `instr_valid`=0, or `instr_valid`=1 and `instr_ready`=1 in the same cycle: load `instr`<=`dip_s` and set `instr_valid`<=1.
    - Otherwise keep `instr` unchanged, drop `dip_s`, and set `overrun`<=1.
    - Then go to HELD.
  - **HELD:** if `btn_s`=0, go to RELEASE with cnt=1.
  - **RELEASE:**
    - If `btn_s`=1, go to HELD (release bounce).
    - If cnt==DEBOUNCE_CYCLES, go to IDLE.
    - Otherwise, cnt++.
- Handshake:
  - A transfer occurs on a clock where `instr_valid` and `instr_ready` are both 1.
  - On a transfer, `instr_valid` drops the next cycle unless FIRE reloads it in the same cycle.
  - `instr` is stable while `instr_valid`=1.
  - `instr_ready` has no effect when `instr_valid`=0.
- `instr_count` increments by 1 on each transfer and wraps 255 -> 0.
- `overrun` clears only on reset.
- Holding the button does not auto-repeat: exactly one FIRE per debounced press.

## Timing
- Reset values:
  - `instr`=0x00, `instr_valid`=0, `overrun`=0, `instr_count`=0, `busy`=0.
  - FSM in IDLE, cnt=0, synchronisers cleared.
- Reset asserted mid-operation aborts any state and drops a pending instruction.
- Press latency, with edge 0 being the first clock that samples raw button high and the button held stable: `instr_valid` is high after edge DEBOUNCE_CYCLES+3.
- `trainer_dip` must be stable at least 3 clocks before FIRE; the value captured is `dip_s` at the FIRE edge.
- Release: IDLE is re-entered DEBOUNCE_CYCLES+1 edges after `btn_s` falls. A new press is not recognised before then.
- There is no combinational path from input to output; all outputs are registered.

## Configuration
- `DIP_DEBOUNCE_EN`:
  - **Defined:** debounce behaviour exactly as above.
  - **Undefined:** ARM and RELEASE are removed and the counter is not built.
    - IDLE goes to FIRE on `btn_s`=1.
    - HELD goes to IDLE on `btn_s`=0.
    - `instr_valid` is high after edge 3.
    - `DEBOUNCE_CYCLES` is ignored.

## Structure
- Shared package `cpu_pkg`:
  - FSM state encoding.
  - Instruction field constants: OPC_MSB/LSB, DST_MSB/LSB, SRC_MSB/LSB.
  - Opcodes OP_ADD=4'b0001 and OP_SUB=4'b0010.
- One natural sub-module, `sync2`: a parameterised-width 2-FF synchroniser with async active-low clear. It is instantiated twice, once with width 1 and once with width 8.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset: hold `rst_n`=0 -> all outputs 0. Assert `rst_n`=0 mid-ARM -> FSM returns to IDLE and `busy`=0 the same cycle.
2. Clean press: dip=8'b00011110, button high 20 cycles, `instr_ready`=1 -> `instr_valid` high after edge 7, `instr`=0x1E, one transfer, `instr_count`=1.
3. Bounce: button pulses 1,0,1,0 at 1-cycle spacing then low -> no `instr_valid`, `instr_count` stays 0.
4. Back-pressure: `instr_ready`=0, press with 0x1E, then press with 0x29 -> `instr` stays 0x1E and `overrun`=1. Then set `instr_ready`=1 -> one transfer, `instr_count`=1.
5. Simultaneous: second FIRE on the same cycle the CPU accepts 0x1E -> `instr` becomes 0x29 with `instr_valid` held 1, and `overrun`=0.
6. Held button, 100 cycles -> exactly one FIRE. Wrap: 256 presses -> `instr_count`=0.
